// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output port. Each word carries
// its header tag; the read side counts packet words and flags the parity word.
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   fill_count,
    output logic              pkt_done,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int CNT_W = DATA_W - 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_V = (ADDR_W + 1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit DATA_W of each entry is the header tag sampled with the word.
    logic [DATA_W:0]     mem_q [DEPTH];

    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic                pkt_done_q, pkt_done_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_W:0]     rd_word;
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-1:0]   rd_idx;

    assign wr_idx      = wr_ptr_q[ADDR_W-1:0];
    assign rd_idx      = rd_ptr_q[ADDR_W-1:0];
    assign rd_word     = mem_q[rd_idx];

    assign fill_count  = wr_ptr_q - rd_ptr_q;
    assign full        = (fill_count == DEPTH_V);
    assign empty       = (fill_count == '0);
    assign almost_full = (fill_count >= AFULL_V);

    assign data_out    = data_out_q;
    assign pkt_done    = pkt_done_q;
    assign ovf_err     = ovf_q;
    assign udf_err     = udf_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;
        pkt_done_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;

        if (reset || soft_reset) begin
            // Flush: any same-cycle read or write is discarded.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            data_out_d = '0;
            pkt_cnt_d  = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            // Full blocks writes even when a read frees a slot this cycle.
            wr_acc = write_enb && !full;
            rd_acc = read_enb && !empty;

            if (write_enb && full)
                ovf_d = 1'b1;
            if (read_enb && empty)
                udf_d = 1'b1;

            if (wr_acc)
                wr_ptr_d = wr_ptr_q + PTR_ONE;

            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                data_out_d = rd_word[DATA_W-1:0];
                if (rd_word[DATA_W]) begin
                    // Header: payload length plus the trailing parity word.
                    pkt_cnt_d = {1'b0, rd_word[DATA_W-1:2]} + CNT_ONE;
                end else if (pkt_cnt_q != '0) begin
                    pkt_cnt_d  = pkt_cnt_q - CNT_ONE;
                    pkt_done_d = (pkt_cnt_q == CNT_ONE);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_idx] <= {lfd_state, data_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
            pkt_cnt_q  <= '0;
            pkt_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pkt_done_q <= pkt_done_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: a vector table for the basic packet
// flow plus hand sequences for full/wrap, streaming, flush and a 12x4 build.
module tb_router_pkt_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0, soft_reset = 1'b0, write_enb = 1'b0, lfd_state = 1'b0, read_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty, almost_full, pkt_done, ovf_err, udf_err;
    logic [4:0] fill_count;

    logic        b_reset = 1'b0, b_soft = 1'b0, b_we = 1'b0, b_lfd = 1'b0, b_re = 1'b0;
    logic [11:0] b_din = 12'h000;
    logic [11:0] b_dout;
    logic        b_full, b_empty, b_af, b_pd, b_ovf, b_udf;
    logic [2:0]  b_fill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_pkt_fifo dut (
        .clk(clk), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
        .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .fill_count(fill_count), .pkt_done(pkt_done), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    router_pkt_fifo #(.DATA_W(12), .DEPTH(4)) dut_b (
        .clk(clk), .reset(b_reset), .soft_reset(b_soft), .write_enb(b_we),
        .lfd_state(b_lfd), .data_in(b_din), .read_enb(b_re),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .fill_count(b_fill), .pkt_done(b_pd), .ovf_err(b_ovf), .udf_err(b_udf)
    );

    typedef struct {
        logic       rst, srst, we, lfd;
        logic [7:0] din;
        logic       re;
        logic [4:0] fill;
        logic       emp, ful, af;
        logic [7:0] dout;
        logic       pd, ovf, udf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic lfd, input logic [7:0] din, input logic re);
        write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;
        tick();
        write_enb = 1'b0; lfd_state = 1'b0; read_enb = 1'b0;
    endtask

    task automatic bdrive(input logic we, input logic lfd, input logic [11:0] din, input logic re);
        b_we = we; b_lfd = lfd; b_din = din; b_re = re;
        tick();
        b_we = 1'b0; b_lfd = 1'b0; b_re = 1'b0;
    endtask

    function automatic vec_t mk(input logic rst, input logic we, input logic lfd,
                                input logic [7:0] din, input logic re, input logic [4:0] fill,
                                input logic [7:0] dout, input logic pd, input logic udf);
        vec_t v;
        v.rst = rst; v.srst = 1'b0; v.we = we; v.lfd = lfd; v.din = din; v.re = re;
        v.fill = fill; v.emp = (fill == 5'd0); v.ful = (fill == 5'd16); v.af = (fill >= 5'd14);
        v.dout = dout; v.pd = pd; v.ovf = 1'b0; v.udf = udf;
        return v;
    endfunction

    initial begin
        //          rst   we    lfd   din    re    fill   dout   pd    udf
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 5'd4, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h5C, 1'b0, 5'd6, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd5, 8'h11, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd4, 8'hA1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 8'hA2, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 8'hA3, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 8'hA4, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h5C, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'h5C, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h5C, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0));
        // write into empty with a same-cycle read: write lands, read is an underflow
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 5'd1, 8'h00, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 8'h33, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0));

        tick();
        foreach (tbl[i]) begin
            reset = tbl[i].rst; soft_reset = tbl[i].srst;
            write_enb = tbl[i].we; lfd_state = tbl[i].lfd; data_in = tbl[i].din;
            read_enb = tbl[i].re;
            tick();
            chk($sformatf("v%0d fill", i), 32'(fill_count), 32'(tbl[i].fill));
            chk($sformatf("v%0d flags", i), {29'd0, empty, full, almost_full},
                {29'd0, tbl[i].emp, tbl[i].ful, tbl[i].af});
            chk($sformatf("v%0d dout", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("v%0d pd/ovf/udf", i), {29'd0, pkt_done, ovf_err, udf_err},
                {29'd0, tbl[i].pd, tbl[i].ovf, tbl[i].udf});
        end
        reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;

        // Fill to full, overflow, full blocks write even with a read.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b0);
            chk("fill_cnt", 32'(fill_count), 32'(i + 1));
            chk("fill_full", 32'(full), 32'(i == 15));
            chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
        end
        drive(1'b1, 1'b0, 8'hFF, 1'b0);
        chk("ovf_cnt", 32'(fill_count), 32'd16);
        chk("ovf_err", 32'(ovf_err), 32'd1);
        drive(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("full_rw_dout", 32'(data_out), 32'h00);
        chk("full_rw_cnt", 32'(fill_count), 32'd15);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_dout", 32'(data_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);

        // Streaming at fill_count 8 across the pointer wrap.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
        chk("stream_pre", 32'(fill_count), 32'd8);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 8'h28 + 8'(k), 1'b1);
            chk("stream_dout", 32'(data_out), 32'h20 + 32'(k));
            chk("stream_cnt", 32'(fill_count), 32'd8);
            chk("stream_pd", 32'(pkt_done), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            chk("stream_tail", 32'(data_out), 32'h34 + 32'(k));
        end

        // Zero-length header, then a packet aborted by a new header.
        drive(1'b1, 1'b1, 8'h01, 1'b0);
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("zlen_hdr_pd", 32'(pkt_done), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("zlen_par_pd", 32'(pkt_done), 32'd1);
        chk("zlen_par_dout", 32'(data_out), 32'h55);
        drive(1'b1, 1'b1, 8'h0C, 1'b0);
        drive(1'b1, 1'b0, 8'h61, 1'b0);
        drive(1'b1, 1'b1, 8'h04, 1'b0);
        drive(1'b1, 1'b0, 8'h62, 1'b0);
        drive(1'b1, 1'b0, 8'h63, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            chk("abort_pd", 32'(pkt_done), 32'(k == 4));
        end

        // Flush mid-packet with a same-cycle write and read.
        drive(1'b1, 1'b1, 8'h08, 1'b0);
        drive(1'b1, 1'b0, 8'hB1, 1'b0);
        drive(1'b1, 1'b0, 8'hB2, 1'b0);
        drive(1'b1, 1'b0, 8'hB3, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("sr_pre_cnt", 32'(fill_count), 32'd3);
        soft_reset = 1'b1;
        drive(1'b1, 1'b0, 8'hDD, 1'b1);
        soft_reset = 1'b0;
        chk("sr_cnt", 32'(fill_count), 32'd0);
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_dout", 32'(data_out), 32'h00);
        chk("sr_ovf", 32'(ovf_err), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("sr_udf", 32'(udf_err), 32'd1);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'hC1 + 8'(k), 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            chk("sr_cnt0_pd", 32'(pkt_done), 32'd0);
        end
        chk("sr_last_dout", 32'(data_out), 32'hC3);

        // 12-bit x 4-deep build.
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        chk("b_reset_empty", 32'(b_empty), 32'd1);
        bdrive(1'b1, 1'b1, 12'h008, 1'b0);
        chk("b_af1", 32'(b_af), 32'd0);
        bdrive(1'b1, 1'b0, 12'h101, 1'b0);
        chk("b_af2", 32'(b_af), 32'd1);
        bdrive(1'b1, 1'b0, 12'h102, 1'b0);
        chk("b_full3", 32'(b_full), 32'd0);
        bdrive(1'b1, 1'b0, 12'h103, 1'b0);
        chk("b_full4", 32'(b_full), 32'd1);
        chk("b_cnt4", 32'(b_fill), 32'd4);
        bdrive(1'b1, 1'b0, 12'hFFF, 1'b0);
        chk("b_ovf", 32'(b_ovf), 32'd1);
        for (int k = 0; k < 4; k++) begin
            bdrive(1'b0, 1'b0, 12'h000, 1'b1);
            chk("b_dout", 32'(b_dout), (k == 0) ? 32'h008 : 32'h100 + 32'(k));
            chk("b_pd", 32'(b_pd), 32'(k == 3));
        end
        chk("b_empty", 32'(b_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
